reg_file_multi: RTL
===================

REG_FILE_MULTI -- requirements
Module: reg_file_multi

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the address width; DEPTH = 2**ADDR_W entries.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning entry 0 is hardwired to zero when 1.
REQ-004 clk  input  1  single clock; all state changes on posedge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 readEn1  input  1  read port 1 enable.
REQ-007 readAddress1  input  ADDR_W  read port 1 address.
REQ-008 readEn2  input  1  read port 2 enable.
REQ-009 readAddress2  input  ADDR_W  read port 2 address.
REQ-010 writeEn  input  1  write request.
REQ-011 writeAddress  input  ADDR_W  write address.
REQ-012 writeData  input  DATA_W  write data.
REQ-013 clearReq  input  1  request a sequential clear of all entries.
REQ-014 readData1  output  DATA_W  registered read port 1 data.
REQ-015 readData2  output  DATA_W  registered read port 2 data.
REQ-016 busy  output  1  high while clear sweep is in progress.
REQ-017 clearDone  output  1  one-cycle pulse when clear sweep finishes.

Function
REQ-018 Write SHALL be accepted at posedge when writeEn=1, busy=0, and not (ZERO_REG=1 and writeAddress=0); otherwise writeEn is ignored.
REQ-019 Each read port SHALL register its result at posedge when its readEn=1; latency one cycle; with readEn=0 the output holds its previous value.
REQ-020 Read data SHALL be the array entry at the read address, except: write-first bypass returns writeData when an accepted write targets the same address in the same cycle.
REQ-021 During a clear sweep, a read of the entry being cleared in that cycle SHALL return 0 (bypass of the clear write).
REQ-022 With ZERO_REG=1, a read of address 0 SHALL return 0 regardless of bypass.
REQ-023 Both read ports SHALL operate independently and may read the same address in the same cycle.
REQ-024 FSM states SHALL be IDLE, CLEAR, DONE.
REQ-025 IDLE -> CLEAR when clearReq=1; sweep index loads 0; busy asserts the following cycle.
REQ-026 In CLEAR, one entry (index) SHALL be written 0 per cycle, index increments; after index DEPTH-1 is cleared, go to DONE; sweep takes exactly DEPTH cycles.
REQ-027 In DONE, clearDone=1 and busy=0 for exactly one cycle, then IDLE; writes are accepted in DONE.
REQ-028 clearReq SHALL be ignored in CLEAR and DONE.
REQ-029 Index SHALL not wrap: counter width ADDR_W, terminal value DEPTH-1 ends the sweep.

Reset
REQ-030 rst=1 SHALL immediately clear all entries to 0, readData1/readData2 to 0, busy/clearDone to 0, FSM to IDLE, index to 0.
REQ-031 rst asserted mid-sweep SHALL abort the sweep; no clearDone pulse is produced.
REQ-032 After rst deasserts, the first posedge SHALL accept reads/writes normally.

Verification
REQ-033 Write 0xDEADBEEF to addr 7, next cycle read port1 addr 7 -> readData1=0xDEADBEEF one cycle later.
REQ-034 Same cycle writeEn addr 3 data 0x12345678 and readEn2 addr 3 -> readData2=0x12345678 at that posedge (bypass).
REQ-035 ZERO_REG=1: write 0xFFFFFFFF to addr 0, then read addr 0 on both ports -> both 0.
REQ-036 Fill entries 1..31 with nonzero, pulse clearReq -> busy high 32 cycles, writes during busy ignored, clearDone one pulse, all reads then 0.
REQ-037 Assert rst at sweep index 10 -> all outputs 0, busy=0, no clearDone, all entries 0.
REQ-038 readEn1=0 while array changes -> readData1 holds prior value.

Source files
------------

// File: rtl/reg_file_multi.sv
// rtl/reg_file_multi.sv - two-read one-write register file with sequential clear sweep
module reg_file_multi #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              readEn1,
  input  logic [ADDR_W-1:0] readAddress1,
  input  logic              readEn2,
  input  logic [ADDR_W-1:0] readAddress2,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] writeAddress,
  input  logic [DATA_W-1:0] writeData,
  input  logic              clearReq,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              busy,
  output logic              clearDone
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t            state, nextState;
  logic [ADDR_W-1:0] sweepIdx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              writeOk;

  assign busy      = (state == CLEAR);
  assign clearDone = (state == DONE);
  assign writeOk   = writeEn && !busy && !((ZERO_REG != 0) && (writeAddress == '0));

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (clearReq) nextState = CLEAR;
      CLEAR:   if (sweepIdx == LAST_IDX) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sweepIdx <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && clearReq)
        sweepIdx <= '0;
      else if (state == CLEAR && sweepIdx != LAST_IDX)
        sweepIdx <= sweepIdx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (busy) begin
      mem[sweepIdx] <= '0;
    end else if (writeOk) begin
      mem[writeAddress] <= writeData;
    end
  end

  // Precedence: hardwired zero, then the clear write, then the user write.
  function automatic logic [DATA_W-1:0] readValue(input logic [ADDR_W-1:0] addr);
    if ((ZERO_REG != 0) && (addr == '0))
      return '0;
    else if (busy && (addr == sweepIdx))
      return '0;
    else if (writeOk && (addr == writeAddress))
      return writeData;
    else
      return mem[addr];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readData1 <= '0;
      readData2 <= '0;
    end else begin
      if (readEn1) readData1 <= readValue(readAddress1);
      if (readEn2) readData2 <= readValue(readAddress2);
    end
  end

endmodule
